// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester.
// Holds the FSM state enum and the WIDTH/TIMEOUT defaults.
package gcd_pkg;

    localparam int GCD_WIDTH   = 16;
    localparam int GCD_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } gcd_state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// Job, core and response signals of the GCD requester.
// slave: requester side; master: job source, core and consumer side.
interface gcd_requester_if #(
    parameter int WIDTH = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] req_a_i;
    logic [WIDTH-1:0] req_b_i;
    logic             gcd_start_o;
    logic [WIDTH-1:0] gcd_a_o;
    logic [WIDTH-1:0] gcd_b_o;
    logic             gcd_done_i;
    logic [WIDTH-1:0] gcd_result_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_result_o;
    logic             rsp_error_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i,
        input  gcd_done_i, gcd_result_i,
        input  rsp_ready_i,
        output req_ready_o,
        output gcd_start_o, gcd_a_o, gcd_b_o,
        output rsp_valid_o, rsp_result_o, rsp_error_o,
        output busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i,
        output gcd_done_i, gcd_result_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  gcd_start_o, gcd_a_o, gcd_b_o,
        input  rsp_valid_o, rsp_result_o, rsp_error_o,
        input  busy_o
    );

endinterface

// File: rtl/gcd_timeout_cnt.sv
// Saturating watchdog counter for the WAIT state.
// clr zeroes, en counts up to TIMEOUT; expired marks the cycle reaching it.
module gcd_timeout_cnt #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // True in the cycle whose increment brings the count to TIMEOUT,
    // so the FSM leaves WAIT after exactly TIMEOUT cycles.
    assign expired = en && (count_q >= LAST);

endmodule

// File: rtl/gcd_requester.sv
// Hands one job at a time to an external GCD core with a watchdog.
// clk/rst_n plain; job, core and response signals through bus.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    gcd_requester_if.slave  bus
);
    gcd_state_e       state_q;
    gcd_state_e       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             err_q;
    logic             err_d;
    logic             load_op;
    logic             load_rsp;
    logic             cnt_clr;
    logic             cnt_en;
    logic             expired;
    logic             a_zero;
    logic             b_zero;

    assign a_zero = (bus.req_a_i == '0);
    assign b_zero = (bus.req_b_i == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_op  = 1'b0;
        load_rsp = 1'b0;
        res_d    = '0;
        err_d    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    load_op = 1'b1;
                    if (!a_zero && !b_zero) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // gcd(x,0)=x; 0/0 is undefined
                        load_rsp = 1'b1;
                        res_d    = bus.req_a_i | bus.req_b_i;
                        err_d    = a_zero && b_zero;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // done has priority over a same-cycle timeout
                if (bus.gcd_done_i) begin
                    load_rsp = 1'b1;
                    res_d    = bus.gcd_result_i;
                    state_d  = ST_RESP;
                end else if (expired) begin
                    load_rsp = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load_op) begin
            a_q <= bus.req_a_i;
            b_q <= bus.req_b_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (load_rsp) begin
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    gcd_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    // ready is masked by rst_n so it stays low while reset is held
    assign bus.req_ready_o  = rst_n && (state_q == ST_IDLE);
    assign bus.gcd_start_o  = (state_q == ST_ISSUE);
    assign bus.gcd_a_o      = a_q;
    assign bus.gcd_b_o      = b_q;
    assign bus.rsp_valid_o  = (state_q == ST_RESP);
    assign bus.rsp_result_o = res_q;
    assign bus.rsp_error_o  = err_q;
    assign bus.busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with TIMEOUT=15.
// Vector table for single jobs plus back-pressure and reset sequences.
module tb_gcd_requester;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    gcd_requester_if #(.WIDTH(W)) bus ();

    gcd_requester #(
        .WIDTH   (W),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           done_cyc;
        logic [W-1:0] done_val;
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           exp_starts;
        int           exp_start_cyc;
        int           exp_rsp_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    task automatic run_vec(int idx, vec_t v);
        int cyc;
        int starts;
        int start_cyc;
        int rsp_cyc;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_a_i = v.a;
        bus.req_b_i = v.b;
        check({t, "_ready"}, 32'(bus.req_ready_o), 1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_a_i = '0;
        bus.req_b_i = '0;
        cyc = 1;
        starts = 0;
        start_cyc = 0;
        rsp_cyc = 0;
        while (cyc <= 40) begin
            if (bus.gcd_start_o) begin
                starts++;
                start_cyc = cyc;
            end
            if (bus.rsp_valid_o) begin
                rsp_cyc = cyc;
                break;
            end
            bus.gcd_done_i = (cyc == v.done_cyc);
            bus.gcd_result_i = (cyc == v.done_cyc) ? v.done_val : '0;
            @(negedge clk);
            cyc++;
        end
        bus.gcd_done_i = 1'b0;
        bus.gcd_result_i = '0;
        check({t, "_op_a"}, 32'(bus.gcd_a_o), 32'(v.a));
        check({t, "_op_b"}, 32'(bus.gcd_b_o), 32'(v.b));
        check({t, "_starts"}, starts, v.exp_starts);
        check({t, "_start_cyc"}, start_cyc, v.exp_start_cyc);
        check({t, "_rsp_cyc"}, rsp_cyc, v.exp_rsp_cyc);
        check({t, "_result"}, 32'(bus.rsp_result_o), 32'(v.exp_res));
        check({t, "_error"}, 32'(bus.rsp_error_o), 32'(v.exp_err));
        check({t, "_busy"}, 32'(bus.busy_o), 1);
        check({t, "_ready_resp"}, 32'(bus.req_ready_o), 0);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check({t, "_rsp_drop"}, 32'(bus.rsp_valid_o), 0);
        check({t, "_idle"}, 32'(bus.busy_o), 0);
        check({t, "_ready_idle"}, 32'(bus.req_ready_o), 1);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_a_i = '0;
        bus.req_b_i = '0;
        bus.gcd_done_i = 1'b0;
        bus.gcd_result_i = '0;
        bus.rsp_ready_i = 1'b0;

        //         a    b   dcyc dval res err st scyc rcyc
        vecs[0] = '{48,  18, 13,  6,   6,  0, 1, 1, 14};
        vecs[1] = '{0,   35, 0,   0,   35, 0, 0, 0, 1};
        vecs[2] = '{0,   0,  0,   0,   0,  1, 0, 0, 1};
        vecs[3] = '{35,  0,  0,   0,   35, 0, 0, 0, 1};
        vecs[4] = '{7,   5,  0,   0,   0,  1, 1, 1, 17};
        vecs[5] = '{81,  18, 16,  9,   9,  0, 1, 1, 17};
        vecs[6] = '{7,   5,  2,   1,   1,  0, 1, 1, 3};
        vecs[7] = '{100, 75, 15,  25,  25, 0, 1, 1, 16};

        #2;
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_start", 32'(bus.gcd_start_o), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        check("rst_gcd_a", 32'(bus.gcd_a_o), 0);
        check("rst_result", 32'(bus.rsp_result_o), 0);
        check("rst_error", 32'(bus.rsp_error_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 32'(bus.req_ready_o), 1);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-pressure: response held while a new job waits.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_a_i = 12;
        bus.req_b_i = 8;
        @(negedge clk);
        bus.req_a_i = 0;
        bus.req_b_i = 5;
        check("bp_start", 32'(bus.gcd_start_o), 1);
        @(negedge clk);
        bus.gcd_done_i = 1'b1;
        bus.gcd_result_i = 4;
        @(negedge clk);
        bus.gcd_result_i = 77;
        check("bp_rsp_valid", 32'(bus.rsp_valid_o), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.rsp_valid_o), 1);
            check("bp_hold_res", 32'(bus.rsp_result_o), 4);
            check("bp_hold_err", 32'(bus.rsp_error_o), 0);
            check("bp_no_ready", 32'(bus.req_ready_o), 0);
            check("bp_no_accept", 32'(bus.gcd_a_o), 12);
        end
        bus.gcd_done_i = 1'b0;
        bus.gcd_result_i = '0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("bp_idle_ready", 32'(bus.req_ready_o), 1);
        check("bp_idle_valid", 32'(bus.rsp_valid_o), 0);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("bp_next_valid", 32'(bus.rsp_valid_o), 1);
        check("bp_next_res", 32'(bus.rsp_result_o), 5);
        check("bp_next_b", 32'(bus.gcd_b_o), 5);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("bp_end_idle", 32'(bus.busy_o), 0);

        // Reset in WAIT, then a late done pulse.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_a_i = 48;
        bus.req_b_i = 18;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(bus.busy_o), 1);
        rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(bus.busy_o), 0);
        check("ar_gcd_a", 32'(bus.gcd_a_o), 0);
        check("ar_gcd_b", 32'(bus.gcd_b_o), 0);
        check("ar_rsp_valid", 32'(bus.rsp_valid_o), 0);
        check("ar_start", 32'(bus.gcd_start_o), 0);
        check("ar_result", 32'(bus.rsp_result_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.gcd_done_i = 1'b1;
        bus.gcd_result_i = 6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.gcd_done_i = 1'b0;
            check("late_no_rsp", 32'(bus.rsp_valid_o), 0);
            check("late_idle", 32'(bus.busy_o), 0);
            check("late_ready", 32'(bus.req_ready_o), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
